instr_fetch_stage: RTL and testbench

Fetch stage plus IF/ID pipeline register of the 16-bit pipelined CPU. It sits directly upstream of the instruction decoder. It holds the PC, drives the word-addressed instruction memory, and latches the fetched instruction and PC+1 into IF/ID for the decoder. It handles load-use stalls, branch/CALL/RET redirects (flush), and stops fetching once HLT (opcode 4'b1111) is fetched.

---
 rtl/instr_fetch_stage_pkg.sv | 23 ++
 rtl/instr_fetch_stage_if_id_reg.sv | 30 +++
 rtl/instr_fetch_stage.sv | 91 +++++++++
 tb/tb_instr_fetch_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Shared CPU definitions: opcodes, default widths, bubble encoding and the fetch FSM states.
package instr_fetch_stage_pkg;

    localparam int PC_W_DEF    = 16;
    localparam int INSTR_W_DEF = 16;

    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_e;

    function automatic logic is_hlt(input logic [3:0] opcode);
        return (opcode == OP_HLT);
    endfunction

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: synchronous clear beats hold, hold beats load.
module if_id_reg #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Pipeline register storage with reset, flush and stall hold
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (hold_i) begin
            data_q <= data_q;
        end else begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, fetch FSM (RUN/HALTED), fetch counter and the IF/ID register feeding the decoder.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter int               PC_W     = PC_W_DEF,
    parameter int               INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0]  RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc_plus1,
    output logic               if_id_valid,
    output logic               fetch_halted,
    output logic [15:0]        fetch_count
);

    localparam int IFID_W = INSTR_W + PC_W + 1;

    fetch_state_e        state_q;
    logic [PC_W-1:0]     pc_q;
    logic [15:0]         count_q;
    logic [PC_W-1:0]     pc_plus1_s;
    logic                ifid_clear_s;
    logic [IFID_W-1:0]   ifid_d;
    logic [IFID_W-1:0]   ifid_q;

    assign pc_plus1_s = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

    // Redirect squashes IF/ID; a halted front end feeds bubbles unless stalled
    assign ifid_clear_s = redirect | ((state_q == FS_HALTED) & ~stall);
    assign ifid_d       = {imem_rdata, pc_plus1_s, 1'b1};

    // PC, fetch FSM and valid-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= FS_RUN;
            count_q <= 16'h0000;
        end else if (redirect) begin
            pc_q    <= redirect_pc;
            state_q <= FS_RUN;
        end else if (stall) begin
            pc_q    <= pc_q;
            state_q <= state_q;
        end else begin
            case (state_q)
                FS_RUN: begin
                    pc_q    <= pc_plus1_s;
                    count_q <= count_q + 16'h0001;
                    if (is_hlt(imem_rdata[INSTR_W-1 -: 4])) begin
                        state_q <= FS_HALTED;
                    end else begin
                        state_q <= FS_RUN;
                    end
                end
                FS_HALTED: begin
                    pc_q    <= pc_q;
                    state_q <= FS_HALTED;
                end
                default: begin
                    state_q <= FS_RUN;
                end
            endcase
        end
    end

    if_id_reg #(
        .W (IFID_W)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (stall),
        .clear_i (ifid_clear_s),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign imem_addr      = pc_q;
    assign if_id_instr    = ifid_q[IFID_W-1 -: INSTR_W];
    assign if_id_pc_plus1 = ifid_q[PC_W:1];
    assign if_id_valid    = ifid_q[0];
    assign fetch_halted   = (state_q == FS_HALTED);
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed self-checking bench for instr_fetch_stage with a small word-addressed instruction memory.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        fetch_halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:63];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Memory aliases modulo 64 words; address 16'hFFFF lands on entry 63
    assign imem_rdata = mem[imem_addr[5:0]];

    instr_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .fetch_halted   (fetch_halted),
        .fetch_count    (fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        step(); step();
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
        checks++; if (if_id_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", if_id_instr); end
        checks++; if (if_id_pc_plus1 !== 16'h0000) begin errors++; $display("FAIL reset_pc1: got %h want 0000", if_id_pc_plus1); end
        checks++; if (fetch_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h want 0000", fetch_count); end
        checks++; if (fetch_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", fetch_halted); end
        rst = 1'b0;
    endtask

    task automatic test_run();
        logic [15:0] exp_instr [0:2];
        exp_instr[0] = 16'h0123; exp_instr[1] = 16'h4567; exp_instr[2] = 16'h89AB;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (imem_addr !== 16'(i + 1)) begin errors++; $display("FAIL run_addr%0d: got %h want %h", i, imem_addr, 16'(i + 1)); end
            checks++; if (if_id_instr !== exp_instr[i]) begin errors++; $display("FAIL run_instr%0d: got %h want %h", i, if_id_instr, exp_instr[i]); end
            checks++; if (if_id_pc_plus1 !== 16'(i + 1)) begin errors++; $display("FAIL run_pc1_%0d: got %h want %h", i, if_id_pc_plus1, 16'(i + 1)); end
            checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL run_valid%0d: got %b want 1", i, if_id_valid); end
        end
        checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL run_count: got %0d want 3", fetch_count); end
    endtask

    task automatic test_stall();
        mem[4] = 16'h4444;
        redirect = 1'b1; redirect_pc = 16'h0004;
        step();
        redirect = 1'b0;
        step();
        checks++; if (imem_addr !== 16'h0005) begin errors++; $display("FAIL stall_pre_addr: got %h want 0005", imem_addr); end
        checks++; if (if_id_instr !== 16'h4444) begin errors++; $display("FAIL stall_pre_instr: got %h want 4444", if_id_instr); end
        checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL stall_pre_count: got %0d want 4", fetch_count); end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (imem_addr !== 16'h0005) begin errors++; $display("FAIL stall_addr%0d: got %h want 0005", i, imem_addr); end
            checks++; if (if_id_instr !== 16'h4444 || if_id_pc_plus1 !== 16'h0005 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid%0d: got %h/%h/%b want 4444/0005/1", i, if_id_instr, if_id_pc_plus1, if_id_valid); end
            checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL stall_count%0d: got %0d want 4", i, fetch_count); end
        end
        stall = 1'b0;
        step();
        checks++; if (imem_addr !== 16'h0006) begin errors++; $display("FAIL stall_rel_addr: got %h want 0006", imem_addr); end
        checks++; if (if_id_instr !== 16'h5555 || if_id_pc_plus1 !== 16'h0006) begin errors++; $display("FAIL stall_rel_ifid: got %h/%h want 5555/0006", if_id_instr, if_id_pc_plus1); end
        checks++; if (fetch_count !== 16'd5) begin errors++; $display("FAIL stall_rel_count: got %0d want 5", fetch_count); end
    endtask

    task automatic test_halt();
        mem[4] = 16'hF000;
        redirect = 1'b1; redirect_pc = 16'h0004;
        step();
        checks++; if (if_id_valid !== 1'b0 || imem_addr !== 16'h0004) begin errors++; $display("FAIL redir_bubble: got valid=%b addr=%h want 0/0004", if_id_valid, imem_addr); end
        redirect = 1'b0;
        step();
        checks++; if (if_id_instr !== 16'hF000 || if_id_pc_plus1 !== 16'h0005 || if_id_valid !== 1'b1) begin errors++; $display("FAIL hlt_ifid: got %h/%h/%b want F000/0005/1", if_id_instr, if_id_pc_plus1, if_id_valid); end
        checks++; if (fetch_halted !== 1'b1) begin errors++; $display("FAIL hlt_halted: got %b want 1", fetch_halted); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (imem_addr !== 16'h0005) begin errors++; $display("FAIL halted_addr%0d: got %h want 0005", i, imem_addr); end
            checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000) begin errors++; $display("FAIL halted_bubble%0d: got %b/%h want 0/0000", i, if_id_valid, if_id_instr); end
            checks++; if (fetch_count !== 16'd6) begin errors++; $display("FAIL halted_count%0d: got %0d want 6", i, fetch_count); end
        end
    endtask

    task automatic test_redirect_halted();
        redirect = 1'b1; redirect_pc = 16'h0020;
        step();
        checks++; if (imem_addr !== 16'h0020) begin errors++; $display("FAIL resume_addr: got %h want 0020", imem_addr); end
        checks++; if (if_id_valid !== 1'b0 || fetch_halted !== 1'b0) begin errors++; $display("FAIL resume_state: got valid=%b halted=%b want 0/0", if_id_valid, fetch_halted); end
        redirect = 1'b0;
        step();
        checks++; if (imem_addr !== 16'h0021 || if_id_instr !== 16'h2020 || if_id_valid !== 1'b1) begin errors++; $display("FAIL resume_fetch: got %h/%h/%b want 0021/2020/1", imem_addr, if_id_instr, if_id_valid); end
        checks++; if (fetch_count !== 16'd7) begin errors++; $display("FAIL resume_count: got %0d want 7", fetch_count); end
    endtask

    task automatic test_redirect_stall_hlt();
        redirect = 1'b1; redirect_pc = 16'h0009;
        step();
        stall = 1'b1; redirect_pc = 16'h0003;
        step();
        checks++; if (imem_addr !== 16'h0003) begin errors++; $display("FAIL rs_addr: got %h want 0003", imem_addr); end
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000 || if_id_pc_plus1 !== 16'h0000) begin errors++; $display("FAIL rs_flush: got %b/%h/%h want 0/0000/0000", if_id_valid, if_id_instr, if_id_pc_plus1); end
        checks++; if (fetch_halted !== 1'b0) begin errors++; $display("FAIL rs_halted: got %b want 0", fetch_halted); end
        checks++; if (fetch_count !== 16'd7) begin errors++; $display("FAIL rs_count: got %0d want 7", fetch_count); end
        stall = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        step();
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr: got %h want 0000", imem_addr); end
        checks++; if (if_id_instr !== 16'h1234 || if_id_pc_plus1 !== 16'h0000 || if_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_ifid: got %h/%h/%b want 1234/0000/1", if_id_instr, if_id_pc_plus1, if_id_valid); end
        step();
        checks++; if (imem_addr !== 16'h0001 || fetch_count !== 16'd9) begin errors++; $display("FAIL prerst: got addr=%h count=%0d want 0001/9", imem_addr, fetch_count); end
        rst = 1'b1;
        step();
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL midrst_addr: got %h want 0000", imem_addr); end
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000 || if_id_pc_plus1 !== 16'h0000) begin errors++; $display("FAIL midrst_ifid: got %b/%h/%h want 0/0000/0000", if_id_valid, if_id_instr, if_id_pc_plus1); end
        checks++; if (fetch_count !== 16'h0000 || fetch_halted !== 1'b0) begin errors++; $display("FAIL midrst_state: got count=%0d halted=%b want 0/0", fetch_count, fetch_halted); end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0123; mem[1] = 16'h4567; mem[2] = 16'h89AB; mem[3] = 16'hAAAA;
        mem[4] = 16'hF000; mem[5] = 16'h5555; mem[6] = 16'h6666; mem[9] = 16'hF000;
        mem[32] = 16'h2020; mem[63] = 16'h1234;
        test_reset();
        test_run();
        test_stall();
        test_halt();
        test_redirect_halted();
        test_redirect_stall_hlt();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
